lsu_mem_master: RTL and testbench

//  Data-side initiator for the unified byte-addressable memory's data port.

---
 rtl/lsu_defs.sv | 21 ++
 rtl/lsu_byte_lane.sv | 45 ++++
 rtl/lsu_mem_master.sv | 159 +++++++++++++++
 tb/tb_lsu_mem_master.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_defs.sv
// Shared definitions for the LSU data-port master.
// Size codes, FSM state encoding and default data-region limit.
package lsu_defs;

    localparam logic [1:0] LSU_SZ_B = 2'b00;
    localparam logic [1:0] LSU_SZ_H = 2'b01;
    localparam logic [1:0] LSU_SZ_W = 2'b10;

    localparam logic [31:0] LSU_DATA_LIMIT = 32'h0000_3000;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RD     = 3'd1,
        S_MERGE  = 3'd2,
        S_WSETUP = 3'd3,
        S_WPULSE = 3'd4,
        S_WREL   = 3'd5,
        S_RESP   = 3'd6
    } lsu_state_e;

endpackage

// File: rtl/lsu_byte_lane.sv
// Byte-lane steering: load extract/extend and store merge.
// Ports: addr_lo/size/sgn select lanes; rword = memory word; wdata = store data; ld_data/st_word results.
module lsu_byte_lane
    import lsu_defs::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        sgn,
    input  logic [31:0] rword,
    input  logic [31:0] wdata,
    output logic [31:0] ld_data,
    output logic [31:0] st_word
);

    logic [7:0]  b;
    logic [15:0] h;

    always_comb begin
        b       = rword[{addr_lo, 3'b000} +: 8];
        h       = addr_lo[1] ? rword[31:16] : rword[15:0];
        ld_data = '0;
        st_word = rword;
        unique case (size)
            LSU_SZ_B: begin
                ld_data = {{24{sgn & b[7]}}, b};
                st_word[{addr_lo, 3'b000} +: 8] = wdata[7:0];
            end
            LSU_SZ_H: begin
                // addr_lo[0] is ignored: half accesses are lane-aligned
                ld_data = {{16{sgn & h[15]}}, h};
                if (addr_lo[1]) st_word[31:16] = wdata[15:0];
                else            st_word[15:0]  = wdata[15:0];
            end
            LSU_SZ_W: begin
                ld_data = rword;
                st_word = wdata;
            end
            default: begin
                ld_data = '0;
                st_word = rword;
            end
        endcase
    end

endmodule

// File: rtl/lsu_mem_master.sv
// Data-side memory master: one load/store at a time, RMW for sub-word stores.
// Ports: req_* from pipeline, rsp_* pulse back, data_addr/data_in/mem_read/mem_write/data_out to memory.
// Macro LSU_MISALIGN_TRAP_EN: misaligned half/word accesses return rsp_err instead of force-aligning.
module lsu_mem_master
    import lsu_defs::*;
#(
    parameter int          RD_WAIT    = 1,
    parameter int          WR_HOLD    = 2,
    parameter logic [31:0] DATA_LIMIT = LSU_DATA_LIMIT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [31:0] data_addr,
    output logic [31:0] data_in,
    output logic        mem_read,
    output logic        mem_write,
    input  logic [31:0] data_out
);

    localparam logic [7:0] RD_LAST = 8'(RD_WAIT);
    localparam logic [7:0] WR_LAST = 8'(WR_HOLD - 1);

    lsu_state_e  state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [1:0]  size_q, size_d;
    logic        sgn_q, sgn_d;
    logic        err_q, err_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] din_q, din_d;
    logic [31:0] rdata_q, rdata_d;

    logic [31:0] ld_data;
    logic [31:0] st_word;
    logic        bad;

    lsu_byte_lane u_lane (
        .addr_lo (addr_q[1:0]),
        .size    (size_q),
        .sgn     (sgn_q),
        .rword   (rdata_q),
        .wdata   (wdata_q),
        .ld_data (ld_data),
        .st_word (st_word)
    );

    always_comb begin
        bad = (req_size == 2'b11) || ((req_addr | 32'd3) >= DATA_LIMIT);
`ifdef LSU_MISALIGN_TRAP_EN
        if ((req_size == LSU_SZ_H && req_addr[0]) ||
            (req_size == LSU_SZ_W && req_addr[1:0] != 2'b00))
            bad = 1'b1;
`endif
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        size_d  = size_q;
        sgn_d   = sgn_q;
        err_d   = err_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        din_d   = din_q;
        rdata_d = rdata_q;
        unique case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    size_d  = req_size;
                    sgn_d   = req_signed;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    err_d   = bad;
                    cnt_d   = '0;
                    if (bad)
                        state_d = S_RESP;
                    else if (req_we && req_size == LSU_SZ_W) begin
                        din_d   = req_wdata;
                        state_d = S_WSETUP;
                    end else
                        state_d = S_RD;
                end
            end
            S_RD: begin
                if (cnt_q == RD_LAST) begin
                    rdata_d = data_out;
                    state_d = we_q ? S_MERGE : S_RESP;
                end else
                    cnt_d = cnt_q + 8'd1;
            end
            S_MERGE: begin
                din_d   = st_word;
                state_d = S_WSETUP;
            end
            S_WSETUP: begin
                cnt_d   = '0;
                state_d = S_WPULSE;
            end
            S_WPULSE: begin
                if (cnt_q == WR_LAST) state_d = S_WREL;
                else                  cnt_d   = cnt_q + 8'd1;
            end
            S_WREL: state_d = S_RESP;
            S_RESP: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            size_q  <= '0;
            sgn_q   <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            din_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            size_q  <= size_d;
            sgn_q   <= sgn_d;
            err_q   <= err_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            din_q   <= din_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        req_ready = (state_q == S_IDLE);
        mem_read  = (state_q == S_RD);
        mem_write = (state_q == S_WPULSE);
        rsp_valid = (state_q == S_RESP);
        rsp_err   = rsp_valid & err_q;
        rsp_rdata = (rsp_valid && !we_q && !err_q) ? ld_data : '0;
        data_addr = {addr_q[31:2], 2'b00};
        data_in   = din_q;
    end

endmodule

// File: tb/tb_lsu_mem_master.sv
// Scoreboard bench for lsu_mem_master.
// Byte memory model, latency/strobe-count/stability checks, reset abort.
module tb_lsu_mem_master;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] data_addr;
    logic [31:0] data_in;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] data_out;

    always #5 clk = ~clk;

    lsu_mem_master dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .data_addr  (data_addr),
        .data_in    (data_in),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .data_out   (data_out)
    );

    logic [7:0] mem [0:16383];
    logic [13:0] ma;
    assign ma = data_addr[13:0];
    assign data_out = {mem[ma + 14'd3], mem[ma + 14'd2],
                       mem[ma + 14'd1], mem[ma]};

    logic [31:0] wr_last_addr = '0;
    logic [31:0] wr_last_data = '0;
    int          wr_total = 0;

    always @(posedge mem_write) begin
        mem[ma]          = data_in[7:0];
        mem[ma + 14'd1]  = data_in[15:8];
        mem[ma + 14'd2]  = data_in[23:16];
        mem[ma + 14'd3]  = data_in[31:24];
        wr_last_addr     = data_addr;
        wr_last_data     = data_in;
        wr_total++;
    end

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    typedef struct {
        string       tag;
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          rd;
        int          wr;
    } exp_t;

    exp_t sb[$];

    localparam int LAT_LD  = 3;
    localparam int LAT_SW  = 5;
    localparam int LAT_SB  = 8;
    localparam int LAT_ERR = 1;

    time         acc_time = 0;
    int          rd_cnt = 0;
    int          wr_cnt = 0;
    logic        unstable = 1'b0;
    logic        prev_act = 1'b0;
    logic [31:0] prev_addr = '0;
    logic [31:0] prev_din = '0;

    always @(negedge clk) begin
        exp_t e;
        int   lat;
        if (mem_read)  rd_cnt++;
        if (mem_write) wr_cnt++;
        if ((mem_read | mem_write) && prev_act &&
            (data_addr !== prev_addr || data_in !== prev_din))
            unstable = 1'b1;
        prev_act  = mem_read | mem_write;
        prev_addr = data_addr;
        prev_din  = data_in;
        if (rsp_valid) begin
            if (sb.size() == 0) begin
                check("spurious_rsp", 32'(rsp_valid), 32'd0);
            end else begin
                e   = sb.pop_front();
                lat = int'(($time - acc_time - 5) / 10) + 1;
                check({e.tag, "_rdata"}, rsp_rdata, e.rdata);
                check({e.tag, "_err"}, 32'(rsp_err), 32'(e.err));
                check({e.tag, "_lat"}, lat, e.lat);
                check({e.tag, "_rdcyc"}, rd_cnt, e.rd);
                check({e.tag, "_wrcyc"}, wr_cnt, e.wr);
                check({e.tag, "_stable"}, 32'(unstable), 32'd0);
            end
        end
    end

    task automatic accept(input logic we, input logic [1:0] sz,
                          input logic sg, input logic [31:0] a,
                          input logic [31:0] wd);
        @(negedge clk);
        check("req_ready_idle", 32'(req_ready), 32'd1);
        req_we     = we;
        req_size   = sz;
        req_signed = sg;
        req_addr   = a;
        req_wdata  = wd;
        req_valid  = 1'b1;
        @(posedge clk);
        acc_time = $time;
        rd_cnt   = 0;
        wr_cnt   = 0;
        unstable = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic req(input string tag, input logic we,
                       input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] er, input logic ee,
                       input int lat, input int rdc, input int wrc);
        exp_t e;
        e.tag   = tag;
        e.rdata = er;
        e.err   = ee;
        e.lat   = lat;
        e.rd    = rdc;
        e.wr    = wrc;
        sb.push_back(e);
        accept(we, sz, sg, a, wd);
        for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            check({tag, "_timeout"}, 32'(sb.size()), 32'd0);
            sb.delete();
        end
    endtask

    int wr_before;

    initial begin
        for (int i = 0; i < 16384; i++) mem[i] = 8'h00;
        mem[16'h10] = 8'h78; mem[16'h11] = 8'h56;
        mem[16'h12] = 8'h34; mem[16'h13] = 8'h12;
        mem[16'h20] = 8'h44; mem[16'h21] = 8'h33;
        mem[16'h22] = 8'h22; mem[16'h23] = 8'h11;

        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_size   = 2'b00;
        req_signed = 1'b0;
        req_addr   = '0;
        req_wdata  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_mem_read", 32'(mem_read), 32'd0);
        check("rst_mem_write", 32'(mem_write), 32'd0);
        check("rst_data_addr", data_addr, 32'd0);
        check("rst_data_in", data_in, 32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'd0);
        check("rst_rsp_err", 32'(rsp_err), 32'd0);
        rst_n = 1'b1;

        req("lw10", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0,
            32'h1234_5678, 1'b0, LAT_LD, 2, 0);

        req("sb13", 1'b1, 2'b00, 1'b0, 32'h13, 32'hFFFF_FF80,
            32'h0, 1'b0, LAT_SB, 2, 2);
        check("sb13_waddr", wr_last_addr, 32'h10);
        check("sb13_wdata", wr_last_data, 32'h8034_5678);

        req("lb13", 1'b0, 2'b00, 1'b1, 32'h13, 32'h0,
            32'hFFFF_FF80, 1'b0, LAT_LD, 2, 0);
        req("lbu13", 1'b0, 2'b00, 1'b0, 32'h13, 32'h0,
            32'h0000_0080, 1'b0, LAT_LD, 2, 0);
        req("lh12", 1'b0, 2'b01, 1'b1, 32'h12, 32'h0,
            32'hFFFF_8034, 1'b0, LAT_LD, 2, 0);
        req("lhu10", 1'b0, 2'b01, 1'b0, 32'h10, 32'h0,
            32'h0000_5678, 1'b0, LAT_LD, 2, 0);

        req("sh22", 1'b1, 2'b01, 1'b0, 32'h22, 32'h1234_BEEF,
            32'h0, 1'b0, LAT_SB, 2, 2);
        check("sh22_waddr", wr_last_addr, 32'h20);
        check("sh22_wdata", wr_last_data, 32'hBEEF_3344);
        req("lw20", 1'b0, 2'b10, 1'b0, 32'h20, 32'h0,
            32'hBEEF_3344, 1'b0, LAT_LD, 2, 0);
        req("lbu21", 1'b0, 2'b00, 1'b0, 32'h21, 32'h0,
            32'h0000_0033, 1'b0, LAT_LD, 2, 0);

        req("sw2ffc", 1'b1, 2'b10, 1'b0, 32'h2FFC, 32'hCAFE_F00D,
            32'h0, 1'b0, LAT_SW, 0, 2);
        check("sw2ffc_wdata", wr_last_data, 32'hCAFE_F00D);
        req("lw2ffc", 1'b0, 2'b10, 1'b0, 32'h2FFC, 32'h0,
            32'hCAFE_F00D, 1'b0, LAT_LD, 2, 0);
        req("lb2fff", 1'b0, 2'b00, 1'b0, 32'h2FFF, 32'h0,
            32'h0000_00CA, 1'b0, LAT_LD, 2, 0);
        wr_before = wr_total;
        req("sw3000", 1'b1, 2'b10, 1'b0, 32'h3000, 32'h1111_2222,
            32'h0, 1'b1, LAT_ERR, 0, 0);
        check("sw3000_nowrite", wr_total, wr_before);
        req("sz11", 1'b0, 2'b11, 1'b0, 32'h10, 32'h0,
            32'h0, 1'b1, LAT_ERR, 0, 0);

`ifdef LSU_MISALIGN_TRAP_EN
        req("lw11", 1'b0, 2'b10, 1'b0, 32'h11, 32'h0,
            32'h0, 1'b1, LAT_ERR, 0, 0);
`else
        req("lw11", 1'b0, 2'b10, 1'b0, 32'h11, 32'h0,
            32'h8034_5678, 1'b0, LAT_LD, 2, 0);
`endif

        accept(1'b1, 2'b10, 1'b0, 32'h100, 32'hDEAD_BEEF);
        for (int i = 0; i < 10 && !mem_write; i++) @(negedge clk);
        check("abort_wpulse_seen", 32'(mem_write), 32'd1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("abort_mem_write", 32'(mem_write), 32'd0);
        check("abort_req_ready", 32'(req_ready), 32'd1);
        check("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);

        req("lw20_post", 1'b0, 2'b10, 1'b0, 32'h20, 32'h0,
            32'hBEEF_3344, 1'b0, LAT_LD, 2, 0);

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
